// File: rtl/h_filt_pkg.sv
// Shared definitions for the horizontal sliding-window filter path:
// controller states, default geometry and a counter-width helper.
package h_filt_pkg;

  localparam int DEF_HIM_LEN   = 520;
  localparam int DEF_VIM_LEN   = 520;
  localparam int DEF_HKER_SIZE = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Never returns 0, so a degenerate size still gives a legal vector.
  function automatic int calc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/h_pix_coord_ctr.sv
// Column/row tracker for the next pixel to accept; wraps at line and frame
// end and flags the final pixel of the frame.
module h_pix_coord_ctr
  import h_filt_pkg::*;
#(
  parameter int HIM_LEN = DEF_HIM_LEN,
  parameter int VIM_LEN = DEF_VIM_LEN,
  parameter int CW      = calc_width(HIM_LEN),
  parameter int RW      = calc_width(VIM_LEN)
) (
  input  logic          clk,
  input  logic          hres_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW:0] COL_LAST = (CW + 1)'(HIM_LEN - 1);
  localparam logic [RW:0] ROW_LAST = (RW + 1)'(VIM_LEN - 1);

  logic col_end;
  logic row_end;

  assign col_end = ({1'b0, col} == COL_LAST);
  assign row_end = ({1'b0, row} == ROW_LAST);
  assign last    = col_end && row_end;

  // Row returns to 0 after the last pixel so it never leaves its legal range.
  always_ff @(posedge clk) begin
    if (!hres_n || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/h_window_ctrl.sv
// Frame controller for the KxK window path: line-buffer clear, pixel
// handshake, window-valid tracking, row-end masks and frame completion.
module h_window_ctrl
  import h_filt_pkg::*;
#(
  parameter int HIM_LEN   = DEF_HIM_LEN,
  parameter int VIM_LEN   = DEF_VIM_LEN,
  parameter int HKER_SIZE = DEF_HKER_SIZE,
  parameter int CW        = calc_width(HIM_LEN),
  parameter int RW        = calc_width(VIM_LEN)
) (
  input  logic                 clk,
  input  logic                 hres_n,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic                 shift_en,
  output logic                 hclrbuffer,
  output logic [HKER_SIZE-2:0] hout,
  output logic [CW-1:0]        col,
  output logic [RW-1:0]        row,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [CW:0] H_LAST   = (CW + 1)'(HIM_LEN - 1);
  localparam logic [CW:0] K_LAST_C = (CW + 1)'(HKER_SIZE - 1);
  localparam logic [RW:0] K_LAST_R = (RW + 1)'(HKER_SIZE - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] clr_ctr;
  logic          coord_clear;
  logic          last_pix;
  logic          qualify;

  h_pix_coord_ctr #(
    .HIM_LEN (HIM_LEN),
    .VIM_LEN (VIM_LEN),
    .CW      (CW),
    .RW      (RW)
  ) u_coord (
    .clk    (clk),
    .hres_n (hres_n),
    .clear  (coord_clear),
    .en     (shift_en),
    .col    (col),
    .row    (row),
    .last   (last_pix)
  );

  // A held result blocks new pixels so nothing in the datapath is overwritten.
  assign s_ready    = (state == RUN) && (!m_valid || m_ready);
  assign shift_en   = s_valid && s_ready;
  assign hclrbuffer = (state == CLEAR);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DRAIN) && (!m_valid || m_ready);

  assign qualify = shift_en && ({1'b0, col} >= K_LAST_C) && ({1'b0, row} >= K_LAST_R);

  always_ff @(posedge clk) begin
    if (!hres_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    coord_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = CLEAR;
          coord_clear = 1'b1;
        end
      end
      CLEAR: begin
        if ({1'b0, clr_ctr} == H_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (shift_en && last_pix) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!hres_n) begin
      clr_ctr <= '0;
    end else if (state == IDLE) begin
      clr_ctr <= '0;
    end else if (state == CLEAR) begin
      clr_ctr <= clr_ctr + CW'(1);
    end
  end

  // A new qualifying accept wins over a simultaneous downstream handshake.
  always_ff @(posedge clk) begin
    if (!hres_n) begin
      m_valid <= 1'b0;
    end else if (qualify) begin
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_comb begin
    hout = '1;
    for (int i = 0; i < HKER_SIZE - 1; i++) begin
      if ({1'b0, col} == H_LAST - (CW + 1)'(i)) begin
        hout[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_h_window_ctrl.sv
// Directed and randomised frame bench for h_window_ctrl on an 8x6 image
// with a 3x3 kernel.
module tb_h_window_ctrl;

  localparam int HIM = 8;
  localparam int VIM = 6;
  localparam int K   = 3;

  logic       clk = 1'b0;
  logic       hres_n;
  logic       start;
  logic       s_valid;
  logic       s_ready;
  logic       m_ready;
  logic       m_valid;
  logic       shift_en;
  logic       hclrbuffer;
  logic [1:0] hout;
  logic [2:0] col;
  logic [2:0] row;
  logic       busy;
  logic       frame_done;

  int test_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  h_window_ctrl #(
    .HIM_LEN   (HIM),
    .VIM_LEN   (VIM),
    .HKER_SIZE (K)
  ) dut (
    .clk        (clk),
    .hres_n     (hres_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .shift_en   (shift_en),
    .hclrbuffer (hclrbuffer),
    .hout       (hout),
    .col        (col),
    .row        (row),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Mask for an 8-wide image with a 3-wide kernel, written out by hand.
  function automatic int expHout(input int c);
    case (c)
      7:       return 2;
      6:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_busy"}, int'(busy), 0);
    checkOutput({pfx, "_m_valid"}, int'(m_valid), 0);
    checkOutput({pfx, "_s_ready"}, int'(s_ready), 0);
    checkOutput({pfx, "_shift_en"}, int'(shift_en), 0);
    checkOutput({pfx, "_hclr"}, int'(hclrbuffer), 0);
    checkOutput({pfx, "_hout"}, int'(hout), 3);
    checkOutput({pfx, "_col"}, int'(col), 0);
    checkOutput({pfx, "_row"}, int'(row), 0);
    checkOutput({pfx, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Pulses start, then measures the clear phase; start is re-pulsed mid-clear.
  task automatic doStart();
    int clr_cycles;
    bit sready_seen;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("hclr_after_start", int'(hclrbuffer), 1);
    clr_cycles  = 0;
    sready_seen = 1'b0;
    for (int i = 0; i < 20 && hclrbuffer; i++) begin
      clr_cycles++;
      if (s_ready) sready_seen = 1'b1;
      start = (i == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("hclr_cycles", clr_cycles, HIM);
    checkOutput("s_ready_in_clear", int'(sready_seen), 0);
    checkOutput("s_ready_after_clear", int'(s_ready), 1);
    checkOutput("busy_after_clear", int'(busy), 1);
  endtask

  // mode 0: constant flow, 1: random, 2: stall on first result, 3: reset at (3,4)
  task automatic applyStimulus(input int mode);
    int er, ec, accepts, hs, stall_cnt;
    bit mv, drained, finished, aborted, acc, qual, exp_sready, exp_fd;
    er = 0; ec = 0; accepts = 0; hs = 0; stall_cnt = 0;
    mv = 1'b0; drained = 1'b0; finished = 1'b0; aborted = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      start = 1'b0;
      case (mode)
        1: begin
          s_valid = 1'($urandom_range(0, 1));
          m_ready = 1'($urandom_range(0, 1));
        end
        2: begin
          s_valid = 1'b1;
          if (mv && hs == 0 && stall_cnt < 4) begin
            m_ready = 1'b0;
            stall_cnt++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: begin
          s_valid = 1'b1;
          m_ready = 1'b1;
        end
      endcase
      if (mode == 0 && cyc == 10) start = 1'b1;
      if (mode == 3 && er == 3 && ec == 4) hres_n = 1'b0;
      #1;
      exp_sready = !drained && (!mv || m_ready);
      exp_fd     = drained && (!mv || m_ready);
      acc        = s_valid && exp_sready;
      checkOutput("m_valid", int'(m_valid), int'(mv));
      checkOutput("s_ready", int'(s_ready), int'(exp_sready));
      checkOutput("shift_en", int'(shift_en), int'(acc));
      checkOutput("frame_done", int'(frame_done), int'(exp_fd));
      if (acc) begin
        checkOutput("col", int'(col), ec);
        checkOutput("row", int'(row), er);
        checkOutput("hout", int'(hout), expHout(ec));
      end
      if (!hres_n) begin
        @(posedge clk); #1;
        checkResetValues("mid_reset");
        hres_n  = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (mv && m_ready) hs++;
      qual = acc && er >= K - 1 && ec >= K - 1;
      mv   = qual ? 1'b1 : (m_ready ? 1'b0 : mv);
      if (acc) begin
        accepts++;
        if (ec == HIM - 1) begin
          ec = 0;
          if (er == VIM - 1) drained = 1'b1;
          else er++;
        end else begin
          ec++;
        end
      end
      if (exp_fd) finished = 1'b1;
      @(posedge clk); #1;
      if (finished) break;
    end
    start = 1'b0;
    if (mode == 3) begin
      checkOutput("reset_reached", int'(aborted), 1);
    end else begin
      checkOutput("frame_finished", int'(finished), 1);
      checkOutput("accept_total", accepts, HIM * VIM);
      checkOutput("handshake_total", hs, (HIM - K + 1) * (VIM - K + 1));
      checkOutput("busy_after_done", int'(busy), 0);
      checkOutput("done_single_pulse", int'(frame_done), 0);
      if (mode == 2) checkOutput("stall_cycles", stall_cnt, 4);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hres_n  = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    hres_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_without_start", int'(busy), 0);

    doStart();
    applyStimulus(0);
    doStart();
    applyStimulus(2);
    doStart();
    applyStimulus(1);
    doStart();
    applyStimulus(3);
    doStart();
    applyStimulus(0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
